vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_pkg.sv | 26 ++
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_timing_gen_mod_counter.sv | 37 +++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and helpers for the VGA timing generator.
// Defaults describe the standard 640x480@60 Hz mode.
package vga_timing_pkg;

    localparam int DEF_CNT_W    = 11;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Total period of one axis: visible region plus porches and sync.
    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // True when a period of 'total' counts is representable in 'width' bits.
    function automatic bit total_fits(input int total, input int width);
        return (total >= 1) && (longint'(total) <= (longint'(1) << width));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of the pixel-enable input and the timing outputs of vga_timing_gen.
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             pix_ce;
    logic [CNT_W-1:0] x_axis;
    logic [CNT_W-1:0] y_axis;
    logic             h_sync;
    logic             v_sync;
    logic             de;
    logic             line_end;
    logic             frame_end;

    // Timing generator side.
    modport master (
        input  pix_ce,
        output x_axis, y_axis, h_sync, v_sync, de, line_end, frame_end
    );

    // Consumer side (display pipeline or bench).
    modport slave (
        output pix_ce,
        input  x_axis, y_axis, h_sync, v_sync, de, line_end, frame_end
    );
endinterface

// File: rtl/vga_timing_gen_mod_counter.sv
// Enable-gated modulo counter with terminal-count flag and reset-load value.
// Also exposes the next-state value so callers can register decodes in step.
module mod_counter #(
    parameter int             W       = 11,
    parameter int             MOD     = 800,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: advance when enabled, returning to zero after LAST.
    always_comb begin
        wrap  = (cnt_q == LAST);
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register, loaded with RST_VAL during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= RST_VAL;
        else        cnt_q <= cnt_d;
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters plus registered
// de/h_sync/v_sync decodes and pix_ce-qualified line/frame end pulses.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] x_axis,
    output logic [CNT_W-1:0] y_axis,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic             line_end,
    output logic             frame_end
);
    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (CNT_W < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        !total_fits(H_TOTAL, CNT_W) || !total_fits(V_TOTAL, CNT_W)) begin : g_param_err
        $fatal(1, "vga_timing_gen: illegal timing parameters");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] x_nxt;
    logic [CNT_W-1:0] y_nxt;
    logic             h_wrap;
    logic             v_wrap;

    // Reset parks both counters on the last pixel of the frame so the first
    // enabled pixel after release produces frame_end and lands on (0,0).
    mod_counter #(.W(CNT_W), .MOD(H_TOTAL), .RST_VAL(H_LAST)) u_h_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .en      (pix_ce),
        .cnt     (x_axis),
        .cnt_nxt (x_nxt),
        .wrap    (h_wrap)
    );

    mod_counter #(.W(CNT_W), .MOD(V_TOTAL), .RST_VAL(V_LAST)) u_v_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .en      (pix_ce & h_wrap),
        .cnt     (y_axis),
        .cnt_nxt (y_nxt),
        .wrap    (v_wrap)
    );

    logic de_q, de_d;
    logic h_sync_q, h_sync_d;
    logic v_sync_q, v_sync_d;

    // Decode from the next counter values so the registered outputs line up
    // with the counters in the same cycle.
    always_comb begin
        de_d     = (x_nxt < H_ACT) && (y_nxt < V_ACT);
        h_sync_d = ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? HS_POL : ~HS_POL;
        v_sync_d = ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? VS_POL : ~VS_POL;
    end

    // Registered, glitch-free display enable and sync outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            de_q     <= 1'b0;
            h_sync_q <= ~HS_POL;
            v_sync_q <= ~VS_POL;
        end else begin
            de_q     <= de_d;
            h_sync_q <= h_sync_d;
            v_sync_q <= v_sync_d;
        end
    end

    assign de     = de_q;
    assign h_sync = h_sync_q;
    assign v_sync = v_sync_q;

    // Pulses are masked by reset so the parked counters never fake an end.
    assign line_end  = rst & pix_ce & h_wrap;
    assign frame_end = line_end & v_wrap;
endmodule
